counter_priority: RTL and testbench
===================================

// Module: counter_priority
// PURPOSE
//  Cycle-stealing arbiter for the involuntary counter cells (TIME1.., CDU, PIPA ...).
//  Latches PINC/MINC increment requests from NCELLS sources.
//  At each memory-cycle boundary (t12) it either grants one whole MCT to the highest-priority pending cell or leaves the cycle to the instruction sequencer.
//  Drives inkl to sq_register and stage_branch, and presents the cell address and operation to the adder path.
// PARAMETERS
//  NCELLS     20        number of counter cells; index 0 = highest priority
//  CTR_BASE   12'o0024  erasable address of cell 0; cell i at CTR_BASE+i
//  CHAIN_MASK 20'h00001 bit i set: overflow/underflow of cell i requests cell i+1
//  MAX_BURST  4         max consecutive counter MCTs before one MCT is yielded
// PORTS
//  clock      in   1       master clock
//  rst        in   1       asynchronous reset, active-high
//  t12        in   1       one-clock pulse on the last timepulse of each MCT
//  gojam      in   1       synchronous restart; aborts the grant, keeps pending bits
//  inhibit    in   1       grants suppressed while high (stop/standby); pending bits still latch
//  pinc_req   in   NCELLS  one-clock request pulses, plus-increment
//  minc_req   in   NCELLS  one-clock request pulses, minus-increment
//  ctr_ovf    in   1       adder overflow of current counter cycle, valid at t12
//  ctr_unf    in   1       adder underflow of current counter cycle, valid at t12
//  inkl       out  1       counter MCT in progress
//  ctr_addr   out  12      address of serviced cell, valid while inkl
//  ctr_op     out  2       CTR_OP_NONE/PINC/MINC, valid while inkl
//  ctr_ack    out  NCELLS  one-clock pulse on the grant clock of cell i
//  chain_drop out  1       one-clock pulse when a chain would go past cell NCELLS-1
// BEHAVIOUR
//  - Reset (async): P,M pending vectors=0, state IDLE, inkl=0, ctr_addr=0, ctr_op=NONE, ctr_ack=0, chain_drop=0, burst=0.
//  - Latch, every clock, per cell i:
//    - pinc&minc in the same clock: both cancel, no change.
//    - pinc with M[i] pending: clear M[i]; with P[i] pending: coalesce (no-op). Symmetric for minc.
//  - Arbitration only on a clock with t12=1; decision takes effect the next clock and is held until the next t12.
//  - States:
//    - IDLE: at t12, if !inhibit && (P|M)!=0 go CNT with w=lowest set index, else stay IDLE.
//    - CNT: at t12 close cycle w, then re-arbitrate. burst<MAX_BURST -> CNT (next w) else YIELD.
//    - YIELD: inkl=0 for one MCT, burst=0, at its t12 arbitrate as IDLE.
//  - Grant: clear P[w] (P wins over M when both set — impossible after cancel); ctr_ack[w] pulses; a new request for w in the grant clock re-latches.
//  - Close of CNT at t12: if op=PINC&&ctr_ovf or op=MINC&&ctr_unf, and CHAIN_MASK[w]:
//    - w<NCELLS-1: set same-type pending of w+1 (same latch rules, before arbitration).
//    - w=NCELLS-1: pulse chain_drop.
//  - Latency: request to inkl is 1-13 clocks (t12 wait + 1); serviced MCT = one t12 interval.
//  - gojam: state->IDLE, inkl=0, op NONE, burst=0 next clock; pending kept; the in-flight cycle is not closed (no chain).
//  - inhibit rising mid-CNT: current MCT completes; no new grant.
//  - ctr_addr = CTR_BASE + w, 12-bit wrap.
// CONFIGURATION
//  - CTR_DIAG_EN defined: adds outputs req_coalesced (1, pulse when a request hits an already-pending same-type bit) and coalesce_cnt (8, saturating at 255, reset 0).
//  - CTR_DIAG_EN undefined: those ports and logic are absent; coalescing is silent.
// STRUCTURE
//  - Shared header modules/ctr_defs.v (package role): CTR_OP_NONE=2'b00, CTR_OP_PINC=2'b01, CTR_OP_MINC=2'b10; state codes IDLE=0, CNT=1, YIELD=2; CTR_BASE default.
//  - Sub-module ctr_prio_enc: NCELLS-wide lowest-index priority encoder -> {valid, index}.
// TESTING
//  1. rst, then pinc_req[3] pulse -> next t12+1: inkl=1, ctr_addr=12'o0027, ctr_op=PINC, ctr_ack[3]=1 for one clock; inkl=0 after the following t12.
//  2. pinc_req[5]&minc_req[5] same clock -> no grant ever; pinc_req[5] then minc_req[5] before t12 -> no grant.
//  3. pinc_req[0] cycle with ctr_ovf=1 at t12 -> cell 1 PINC granted in the next MCT; CTR_BASE+1 on ctr_addr.
//  4. pending cells 0..5 -> grants 0,1,2,3, one YIELD MCT with inkl=0, then 4,5.
//  5. gojam mid-CNT with cell 2 in service and ctr_ovf=1 -> inkl=0 next clock, no chain to cell 3; cell 7 still pending and granted at next t12.
//  6. rst asserted mid-CNT -> all outputs 0 immediately; no grants after release until new requests arrive.

Source files
------------

// File: rtl/counter_priority_pkg.sv
// Shared definitions for the counter-cell priority arbiter: operation codes,
// FSM state encoding and default geometry.
package counter_priority_pkg;

    localparam logic [1:0] CTR_OP_NONE = 2'b00;
    localparam logic [1:0] CTR_OP_PINC = 2'b01;
    localparam logic [1:0] CTR_OP_MINC = 2'b10;

    localparam int         CTR_NCELLS_DEF    = 20;
    localparam logic [11:0] CTR_BASE_DEF     = 12'o0024;
    localparam int         CTR_MAX_BURST_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CNT   = 2'd1,
        ST_YIELD = 2'd2
    } ctr_state_t;

endpackage

// File: rtl/counter_priority_ctr_prio_enc.sv
// Lowest-index-wins priority encoder over the pending-cell vector.
// Purely combinational; index is 0 when nothing is pending.
module ctr_prio_enc #(
    parameter int N = 20,
    parameter int W = 5
) (
    input  logic [N-1:0] i_req,
    output logic         o_vld,
    output logic [W-1:0] o_idx
);

    always_comb begin
        o_vld = |i_req;
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/counter_priority.sv
// Cycle-stealing arbiter: latches PINC/MINC requests and grants whole MCTs at t12.
// Optional CTR_DIAG_EN adds coalesced-request pulse and saturating counter outputs.
module counter_priority
    import counter_priority_pkg::*;
#(
    parameter int              NCELLS     = CTR_NCELLS_DEF,
    parameter logic [11:0]     CTR_BASE   = CTR_BASE_DEF,
    parameter logic [NCELLS-1:0] CHAIN_MASK = 1,
    parameter int              MAX_BURST  = CTR_MAX_BURST_DEF
) (
    input  logic              i_clock,
    input  logic              i_rst,
    input  logic              i_t12,
    input  logic              i_gojam,
    input  logic              i_inhibit,
    input  logic [NCELLS-1:0] i_pinc_req,
    input  logic [NCELLS-1:0] i_minc_req,
    input  logic              i_ctr_ovf,
    input  logic              i_ctr_unf,
    output logic              o_inkl,
    output logic [11:0]       o_ctr_addr,
    output logic [1:0]        o_ctr_op,
    output logic [NCELLS-1:0] o_ctr_ack,
    output logic              o_chain_drop
`ifdef CTR_DIAG_EN
    ,
    output logic              o_req_coalesced,
    output logic [7:0]        o_coalesce_cnt
`endif
);

    localparam int IW = (NCELLS > 1) ? $clog2(NCELLS) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    ctr_state_t        r_state;
    ctr_state_t        w_state_nxt;
    logic [NCELLS-1:0] r_p;
    logic [NCELLS-1:0] r_m;
    logic [IW-1:0]     r_w;
    logic [1:0]        r_op;
    logic [BW-1:0]     r_burst;
    logic [NCELLS-1:0] r_ack;
    logic              r_drop;

    logic              w_close;
    logic              w_carry;
    logic              w_chain;
    logic [NCELLS-1:0] w_wsel;
    logic [NCELLS-1:0] w_chain_vec;
    logic [NCELLS-1:0] w_cp;
    logic [NCELLS-1:0] w_cm;
    logic [NCELLS-1:0] w_p1;
    logic [NCELLS-1:0] w_m1;
    logic [NCELLS-1:0] w_pe;
    logic [NCELLS-1:0] w_me;
    logic [NCELLS-1:0] w_p2;
    logic [NCELLS-1:0] w_m2;
    logic              w_enc_vld;
    logic [IW-1:0]     w_enc_idx;
    logic              w_burst_full;
    logic              w_grant;
    logic [NCELLS-1:0] w_gsel;
    logic              w_gp;

    // Closing a counter MCT may carry into the next cell; a carry out of the
    // last cell shifts off the top of w_wsel and is reported as a drop instead.
    always_comb begin
        w_close     = (r_state == ST_CNT) && i_t12 && !i_gojam;
        w_carry     = ((r_op == CTR_OP_PINC) && i_ctr_ovf) ||
                      ((r_op == CTR_OP_MINC) && i_ctr_unf);
        w_chain     = w_close && w_carry && CHAIN_MASK[r_w];
        w_wsel      = NCELLS'(1) << r_w;
        w_chain_vec = w_chain ? (w_wsel << 1) : '0;
        w_cp        = (r_op == CTR_OP_PINC) ? w_chain_vec : '0;
        w_cm        = (r_op == CTR_OP_MINC) ? w_chain_vec : '0;
    end

    // Chain injection is latched first, then this clock's external pulses.
    always_comb begin
        w_p1 = (r_p & ~w_cm) | (w_cp & ~r_m);
        w_m1 = (r_m & ~w_cp) | (w_cm & ~r_p);
        w_pe = i_pinc_req & ~i_minc_req;
        w_me = i_minc_req & ~i_pinc_req;
        w_p2 = (w_p1 & ~w_me) | (w_pe & ~w_m1);
        w_m2 = (w_m1 & ~w_pe) | (w_me & ~w_p1);
    end

    ctr_prio_enc #(
        .N (NCELLS),
        .W (IW)
    ) u_enc (
        .i_req (w_p2 | w_m2),
        .o_vld (w_enc_vld),
        .o_idx (w_enc_idx)
    );

    always_comb begin
        w_burst_full = (r_state == ST_CNT) && (r_burst >= BW'(MAX_BURST));
        w_grant      = i_t12 && !i_gojam && !i_inhibit && w_enc_vld && !w_burst_full;
        w_gsel       = NCELLS'(1) << w_enc_idx;
        w_gp         = |(w_p2 & w_gsel);
    end

    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_gojam) begin
            w_state_nxt = ST_IDLE;
        end else if (i_t12) begin
            if (w_burst_full) begin
                w_state_nxt = ST_YIELD;
            end else if (w_grant) begin
                w_state_nxt = ST_CNT;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_comb begin
        o_inkl       = (r_state == ST_CNT);
        o_ctr_addr   = o_inkl ? (CTR_BASE + 12'(r_w)) : 12'd0;
        o_ctr_op     = o_inkl ? r_op : CTR_OP_NONE;
        o_ctr_ack    = r_ack;
        o_chain_drop = r_drop;
    end

    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) begin
            r_p     <= '0;
            r_m     <= '0;
            r_w     <= '0;
            r_op    <= CTR_OP_NONE;
            r_burst <= '0;
            r_ack   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_p    <= (w_grant && w_gp)  ? (w_p2 & ~w_gsel) : w_p2;
            r_m    <= (w_grant && !w_gp) ? (w_m2 & ~w_gsel) : w_m2;
            r_ack  <= w_grant ? w_gsel : '0;
            r_drop <= w_chain && (r_w == IW'(NCELLS - 1));
            if (i_gojam) begin
                r_op <= CTR_OP_NONE;
            end else if (w_grant) begin
                r_w  <= w_enc_idx;
                r_op <= w_gp ? CTR_OP_PINC : CTR_OP_MINC;
            end
            if (i_gojam) begin
                r_burst <= '0;
            end else if (w_grant) begin
                r_burst <= (r_state == ST_CNT) ? (r_burst + BW'(1)) : BW'(1);
            end else if (i_t12) begin
                r_burst <= '0;
            end
        end
    end

`ifdef CTR_DIAG_EN
    logic       w_coal;
    logic       r_coal;
    logic [7:0] r_coal_cnt;

    assign w_coal = |((w_pe & w_p1) | (w_me & w_m1));

    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) begin
            r_coal     <= 1'b0;
            r_coal_cnt <= 8'd0;
        end else begin
            r_coal <= w_coal;
            if (w_coal && (r_coal_cnt != 8'hFF)) begin
                r_coal_cnt <= r_coal_cnt + 8'd1;
            end
        end
    end

    assign o_req_coalesced = r_coal;
    assign o_coalesce_cnt  = r_coal_cnt;
`endif

endmodule

// File: tb/tb_counter_priority.sv
// Directed bench for counter_priority: per-clock vector table plus hand sequences
// for burst/yield, gojam abort and asynchronous reset.
module tb_counter_priority;

    logic        clk = 1'b0;
    logic        rst;
    logic        t12, gojam, inhibit, ovf, unf;
    logic [19:0] pinc, minc;
    logic        inkl;
    logic [11:0] addr;
    logic [1:0]  op;
    logic [19:0] ack;
    logic        drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_priority #(
        .NCELLS     (20),
        .CTR_BASE   (12'o0024),
        .CHAIN_MASK (20'h80005),
        .MAX_BURST  (4)
    ) dut (
        .i_clock      (clk),
        .i_rst        (rst),
        .i_t12        (t12),
        .i_gojam      (gojam),
        .i_inhibit    (inhibit),
        .i_pinc_req   (pinc),
        .i_minc_req   (minc),
        .i_ctr_ovf    (ovf),
        .i_ctr_unf    (unf),
        .o_inkl       (inkl),
        .o_ctr_addr   (addr),
        .o_ctr_op     (op),
        .o_ctr_ack    (ack),
        .o_chain_drop (drop)
    );

    typedef struct {
        logic [19:0] p;
        logic [19:0] m;
        logic        t12;
        logic        ovf;
        logic        unf;
        logic        gj;
        logic        inh;
        logic [35:0] exp;
    } vec_t;

    vec_t tv[$];

    function automatic logic [35:0] outs();
        return {inkl, addr, op, ack, drop};
    endfunction

    function automatic logic [35:0] ex(input logic e_inkl, input logic [11:0] e_addr,
                                       input logic [1:0] e_op, input logic [19:0] e_ack,
                                       input logic e_drop);
        return {e_inkl, e_addr, e_op, e_ack, e_drop};
    endfunction

    task automatic add(input logic [19:0] p, input logic [19:0] m, input logic t, input logic o,
                       input logic u, input logic [35:0] e);
        vec_t v;
        v.p = p; v.m = m; v.t12 = t; v.ovf = o; v.unf = u; v.gj = 1'b0; v.inh = 1'b0; v.exp = e;
        tv.push_back(v);
    endtask

    task automatic drive(input logic [19:0] p, input logic [19:0] m, input logic t,
                         input logic o, input logic u, input logic gj, input logic inh);
        pinc = p; minc = m; t12 = t; ovf = o; unf = u; gojam = gj; inhibit = inh;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [35:0] got, input logic [35:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    localparam logic [35:0] IDLE_O = 36'd0;

    logic [11:0] t4_addr[8] = '{12'o0024, 12'o0025, 12'o0026, 12'o0027,
                                12'o0000, 12'o0030, 12'o0031, 12'o0000};
    int          t4_cell[8] = '{0, 1, 2, 3, -1, 4, 5, -1};

    initial begin
        rst = 1'b1;
        drive('0, '0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", outs(), IDLE_O);
        rst = 1'b0;
        step();

        // single PINC on cell 3
        add(20'h8, 0, 0, 0, 0, IDLE_O);
        add(0, 0, 1, 0, 0, ex(1, 12'o0027, 2'b01, 20'h8, 0));
        add(0, 0, 0, 0, 0, ex(1, 12'o0027, 2'b01, 20'h0, 0));
        add(0, 0, 0, 0, 0, ex(1, 12'o0027, 2'b01, 20'h0, 0));
        add(0, 0, 1, 0, 0, IDLE_O);
        // cell 0 overflow chains PINC into cell 1 in the next MCT
        add(20'h1, 0, 0, 0, 0, IDLE_O);
        add(0, 0, 1, 0, 0, ex(1, 12'o0024, 2'b01, 20'h1, 0));
        add(0, 0, 0, 0, 0, ex(1, 12'o0024, 2'b01, 20'h0, 0));
        add(0, 0, 1, 1, 0, ex(1, 12'o0025, 2'b01, 20'h2, 0));
        add(0, 0, 1, 1, 0, IDLE_O);
        // MINC on unchained cell 6
        add(0, 20'h40, 0, 0, 0, IDLE_O);
        add(0, 0, 1, 0, 0, ex(1, 12'o0032, 2'b10, 20'h40, 0));
        add(0, 0, 1, 0, 1, IDLE_O);
        // cancel: same clock, then opposite pulses before t12
        add(20'h20, 20'h20, 0, 0, 0, IDLE_O);
        add(0, 0, 1, 0, 0, IDLE_O);
        add(20'h20, 0, 0, 0, 0, IDLE_O);
        add(0, 20'h20, 0, 0, 0, IDLE_O);
        add(0, 0, 1, 0, 0, IDLE_O);
        // MINC cell 0 with overflow (not underflow) must not chain
        add(0, 20'h1, 0, 0, 0, IDLE_O);
        add(0, 0, 1, 0, 0, ex(1, 12'o0024, 2'b10, 20'h1, 0));
        add(0, 0, 1, 1, 0, IDLE_O);
        // last cell overflow drops the chain
        add(20'h80000, 0, 0, 0, 0, IDLE_O);
        add(0, 0, 1, 0, 0, ex(1, 12'o0047, 2'b01, 20'h80000, 0));
        add(0, 0, 1, 1, 0, ex(0, 12'o0000, 2'b00, 20'h0, 1));
        add(0, 0, 0, 0, 0, IDLE_O);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].p, tv[i].m, tv[i].t12, tv[i].ovf, tv[i].unf, tv[i].gj, tv[i].inh);
            step();
            chk($sformatf("vec%0d", i), outs(), tv[i].exp);
        end
        drive('0, '0, 0, 0, 0, 0, 0);

        // inhibit at t12 holds the request; next free t12 grants it
        drive(20'h4, '0, 0, 0, 0, 0, 0); step();
        drive('0, '0, 1, 0, 0, 0, 1); step();
        chk("inhibit_hold", outs(), IDLE_O);
        drive('0, '0, 1, 0, 0, 0, 0); step();
        chk("inhibit_release", outs(), ex(1, 12'o0026, 2'b01, 20'h4, 0));
        drive('0, '0, 1, 0, 0, 0, 1); step();
        chk("inhibit_mid_cnt", outs(), IDLE_O);

        // cells 0..5 pending: four grants, one yielded MCT, then 4 and 5
        drive(20'h3F, '0, 0, 0, 0, 0, 0); step();
        for (int k = 0; k < 8; k++) begin
            drive('0, '0, 0, 0, 0, 0, 0); step();
            drive('0, '0, 1, 0, 0, 0, 0); step();
            if (t4_cell[k] >= 0)
                chk($sformatf("burst%0d", k), outs(),
                    ex(1, t4_addr[k], 2'b01, 20'(1) << t4_cell[k], 0));
            else
                chk($sformatf("burst%0d", k), outs(), IDLE_O);
        end

        // gojam aborts cell 2 (chained cell) without carrying into cell 3
        drive(20'h84, '0, 0, 0, 0, 0, 0); step();
        drive('0, '0, 1, 0, 0, 0, 0); step();
        chk("gojam_pre", outs(), ex(1, 12'o0026, 2'b01, 20'h4, 0));
        drive('0, '0, 0, 1, 0, 1, 0); step();
        chk("gojam_abort", outs(), IDLE_O);
        drive('0, '0, 1, 1, 0, 0, 0); step();
        chk("gojam_next", outs(), ex(1, 12'o0033, 2'b01, 20'h80, 0));
        drive('0, '0, 1, 0, 0, 0, 0); step();
        chk("gojam_done", outs(), IDLE_O);

        // asynchronous reset mid-CNT clears outputs and pending state
        drive(20'h10 | 20'h200, '0, 0, 0, 0, 0, 0); step();
        drive('0, '0, 1, 0, 0, 0, 0); step();
        chk("rst_pre", outs(), ex(1, 12'o0030, 2'b01, 20'h10, 0));
        drive('0, '0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 chk("rst_async", outs(), IDLE_O);
        #2 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive('0, '0, 1, 0, 0, 0, 0); step();
            chk($sformatf("rst_quiet%0d", k), outs(), IDLE_O);
        end
        drive(20'h2, '0, 0, 0, 0, 0, 0); step();
        drive('0, '0, 1, 0, 0, 0, 0); step();
        chk("rst_new_req", outs(), ex(1, 12'o0025, 2'b01, 20'h2, 0));
        drive('0, '0, 0, 0, 0, 0, 0); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end, required completion");
        $fatal(1, "timeout");
    end

endmodule
